e_muldiv: RTL

//  - E-stage multiply/divide unit. It consumes E_IR-decoded md_op plus E_rs/E_rt straight out of the D/E pipeline register.
//  - Holds the architectural HI/LO registers.
//  - Models multi-cycle mult/div latency. The hazard unit uses busy/start to stall D on any md instruction.

---
 rtl/mips_defs.sv | 15 +
 rtl/e_muldiv.sv | 71 +++++++
 2 files changed

// File: rtl/mips_defs.sv
// mips_defs: md_op codes and mult/div FSM states shared by decode, hazard and e_muldiv
package mips_defs;
  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_e;
  typedef enum logic {MD_IDLE = 1'b0, MD_RUN = 1'b1} md_state_e;
endpackage

// File: rtl/e_muldiv.sv
// e_muldiv: E-stage mult/div unit holding HI/LO with modelled multi-cycle latency
module e_muldiv
  import mips_defs::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic        busy,
  output logic        start,
  output logic [31:0] md_out,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  md_state_e state, state_nx;
  logic [CW-1:0] cnt;
  logic [31:0] res_hi, res_lo;
  logic res_wr;
  logic is_mul, is_div, sdiv;
  logic [63:0] prod;
  logic [31:0] a_mag, b_mag, q, r, div_hi, div_lo;
  assign busy = state == MD_RUN;
  always_comb begin
    is_mul   = md_op == MD_MULT || md_op == MD_MULTU;
    is_div   = md_op == MD_DIV || md_op == MD_DIVU;
    sdiv     = md_op == MD_DIV;
    start    = (is_mul || is_div) && state == MD_IDLE;
    prod     = md_op == MD_MULT ? 64'($signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt}))
                                : {32'b0, rs} * {32'b0, rt};
    // divide magnitudes so INT_MIN / -1 wraps cleanly; zero divisor is replaced, result discarded
    a_mag    = sdiv && rs[31] ? -rs : rs;
    b_mag    = rt == 32'd0 ? 32'd1 : (sdiv && rt[31] ? -rt : rt);
    q        = a_mag / b_mag;
    r        = a_mag % b_mag;
    div_lo   = sdiv && (rs[31] ^ rt[31]) ? -q : q;
    div_hi   = sdiv && rs[31] ? -r : r;
    md_out   = md_op == MD_MFHI ? hi : md_op == MD_MFLO ? lo : 32'd0;
    state_nx = state == MD_RUN ? (cnt == '0 ? MD_IDLE : MD_RUN) : (start ? MD_RUN : MD_IDLE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= MD_IDLE;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      res_hi <= '0;
      res_lo <= '0;
      res_wr <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == MD_RUN) begin
        if (cnt != '0) cnt <= cnt - CW'(1);
        else if (res_wr) begin
          hi <= res_hi;
          lo <= res_lo;
        end
      end else if (start) begin
        {res_hi, res_lo} <= is_mul ? prod : {div_hi, div_lo};
        res_wr <= is_mul || rt != 32'd0;
        cnt    <= is_mul ? CW'(MULT_CYCLES - 1) : CW'(DIV_CYCLES - 1);
      end else if (md_op == MD_MTHI) hi <= rs;
      else if (md_op == MD_MTLO) lo <= rs;
    end
  end
endmodule
